// File: rtl/key_search_dispatcher.sv
// key_search_dispatcher
//   Brute-force key search controller. Walks an inclusive key range and hands
//   keys to NUM_CORES parallel decrypt/check cores. Each core gets at most one
//   key at a time. The first valid result stops further launches, and the
//   search waits until every in-flight core has reported back.
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   crack_start             level request to run a search
//   key_lo, key_hi          inclusive search range, latched in LOAD
//   core_finish/core_valid  per-core result handshake inputs
//   core_start/core_ack     per-core one-cycle launch / acknowledge pulses
//   core_key                per-core key, slice i = core i, zero-extended
//   found_key               winning key, zero-extended
//   busy, done, found       search status flags
//   keys_tried              number of results acknowledged in this search
//   LEDR                    bit0 = found, bit1 = done without a valid key
module key_search_dispatcher #(
    parameter int unsigned KEY_W     = 22,
    parameter int unsigned SECRET_W  = 24,
    parameter int unsigned NUM_CORES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          crack_start,
    input  logic [KEY_W-1:0]              key_lo,
    input  logic [KEY_W-1:0]              key_hi,
    input  logic [NUM_CORES-1:0]          core_finish,
    input  logic [NUM_CORES-1:0]          core_valid,
    output logic [NUM_CORES-1:0]          core_start,
    output logic [NUM_CORES*SECRET_W-1:0] core_key,
    output logic [NUM_CORES-1:0]          core_ack,
    output logic [SECRET_W-1:0]           found_key,
    output logic                          busy,
    output logic                          done,
    output logic                          found,
    output logic [KEY_W:0]                keys_tried,
    output logic [9:0]                    LEDR
);

    localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_CORES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DISPATCH,
        S_DRAIN,
        S_DONE_VALID,
        S_DONE_INVALID
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [KEY_W:0]        r_next_key;
    logic [KEY_W:0]        r_key_hi;
    logic [NUM_CORES-1:0]  r_busy;
    logic [NUM_CORES-1:0]  r_core_start;
    logic [NUM_CORES-1:0]  r_core_ack;
    logic [SECRET_W-1:0]   r_core_key [NUM_CORES];
    logic [SECRET_W-1:0]   r_found_key;
    logic [KEY_W:0]        r_keys_tried;
    logic                  r_busy_flag;
    logic                  r_done;
    logic                  r_found;
    logic [9:0]            r_ledr;

    logic [NUM_CORES-1:0]  w_ack_set;
    logic [NUM_CORES-1:0]  w_valid_hit;
    logic                  w_any_valid;
    logic [IDX_W-1:0]      w_win_idx;
    logic                  w_free_any;
    logic [IDX_W-1:0]      w_free_idx;
    logic [CNT_W-1:0]      w_ack_cnt;
    logic                  w_keys_left;
    logic                  w_launch;

    always_comb begin
        // Finish is only honoured on cores that hold a key; busy clears with
        // the ack, so a finish still held during the ack cycle is not re-acked.
        w_ack_set   = core_finish & r_busy;
        w_valid_hit = w_ack_set & core_valid;
        w_any_valid = 1'b0;
        w_win_idx   = '0;
        w_free_any  = 1'b0;
        w_free_idx  = '0;
        w_ack_cnt   = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (w_valid_hit[i] && !w_any_valid) begin
                w_any_valid = 1'b1;
                w_win_idx   = IDX_W'(i);
            end
            if (!r_busy[i] && !w_free_any) begin
                w_free_any = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            w_ack_cnt = w_ack_cnt + CNT_W'(w_ack_set[i]);
        end
        // next_key carries an extra bit so an all-ones key_hi ends the range
        // instead of wrapping back to zero.
        w_keys_left = (r_next_key <= r_key_hi);
        // A valid result suppresses the launch in the same cycle it is seen.
        w_launch    = (r_state == S_DISPATCH) && w_keys_left && w_free_any && !w_any_valid;

        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:         if (crack_start) w_state_nxt = S_LOAD;
            S_LOAD:         w_state_nxt = (key_lo > key_hi) ? S_DONE_INVALID : S_DISPATCH;
            S_DISPATCH: begin
                if (w_any_valid)
                    w_state_nxt = S_DRAIN;
                else if (!w_keys_left && (r_busy == '0))
                    w_state_nxt = S_DONE_INVALID;
            end
            S_DRAIN:        if (r_busy == '0) w_state_nxt = S_DONE_VALID;
            S_DONE_VALID,
            S_DONE_INVALID: if (!crack_start) w_state_nxt = S_IDLE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_next_key   <= '0;
            r_key_hi     <= '0;
            r_busy       <= '0;
            r_core_start <= '0;
            r_core_ack   <= '0;
            r_found_key  <= '0;
            r_keys_tried <= '0;
            r_busy_flag  <= 1'b0;
            r_done       <= 1'b0;
            r_found      <= 1'b0;
            r_ledr       <= '0;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                r_core_key[i] <= '0;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_core_start <= '0;
            r_core_ack   <= w_ack_set;
            r_busy       <= r_busy & ~w_ack_set;
            r_keys_tried <= r_keys_tried + (KEY_W+1)'(w_ack_cnt);

            if (w_launch) begin
                r_core_start[w_free_idx] <= 1'b1;
                r_core_key[w_free_idx]   <= SECRET_W'(r_next_key[KEY_W-1:0]);
                r_busy[w_free_idx]       <= 1'b1;
                r_next_key               <= r_next_key + (KEY_W+1)'(1);
            end

            if ((r_state == S_DISPATCH) && w_any_valid) begin
                r_found_key <= r_core_key[w_win_idx];
            end

            if (r_state == S_LOAD) begin
                r_next_key   <= {1'b0, key_lo};
                r_key_hi     <= {1'b0, key_hi};
                r_keys_tried <= '0;
                r_found_key  <= '0;
                r_busy       <= '0;
                r_ledr       <= '0;
            end

            // Status flags are registered from the next state so they line up
            // with the state register.
            r_busy_flag <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_DISPATCH) ||
                           (w_state_nxt == S_DRAIN);
            r_done      <= (w_state_nxt == S_DONE_VALID) || (w_state_nxt == S_DONE_INVALID);
            r_found     <= (w_state_nxt == S_DONE_VALID);
            if (w_state_nxt == S_DONE_VALID) begin
                r_ledr <= 10'b00_0000_0001;
            end else if (w_state_nxt == S_DONE_INVALID) begin
                r_ledr <= 10'b00_0000_0010;
            end
        end
    end

    always_comb begin
        core_key = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            core_key[i*SECRET_W +: SECRET_W] = r_core_key[i];
        end
    end

    assign core_start = r_core_start;
    assign core_ack   = r_core_ack;
    assign found_key  = r_found_key;
    assign keys_tried = r_keys_tried;
    assign busy       = r_busy_flag;
    assign done       = r_done;
    assign found      = r_found;
    assign LEDR       = r_ledr;

endmodule
